// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating back-pressure counter.
module mem_wb_skid_stage #(
    parameter int unsigned WB_W   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] ALU_o_i,
    input  logic [RD_W-1:0]   Rd_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] ALU_o_o,
    output logic [RD_W-1:0]   Rd_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WB_W-1:0]     main_wb_q, main_wb_d;
    logic [DATA_W-1:0]   main_rdata_q, main_rdata_d;
    logic [DATA_W-1:0]   main_alu_q, main_alu_d;
    logic [RD_W-1:0]     main_rd_q, main_rd_d;
    logic [WB_W-1:0]     skid_wb_q, skid_wb_d;
    logic [DATA_W-1:0]   skid_rdata_q, skid_rdata_d;
    logic [DATA_W-1:0]   skid_alu_q, skid_alu_d;
    logic [RD_W-1:0]     skid_rd_q, skid_rd_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept;
    logic                drain;

    assign valid_o     = (state_q != S_EMPTY);
    assign occ_o       = 2'(state_q);
    assign WB_o        = main_wb_q;
    assign read_data_o = main_rdata_q;
    assign ALU_o_o     = main_alu_q;
    assign Rd_o        = main_rd_q;
    assign stall_cnt_o = stall_q;

    // Skid mode decodes ready from state only, cutting the ready_i path.
    if (SKID != 0) begin : g_skid_ready
        assign ready_o = (state_q != S_TWO);
    end else begin : g_pass_ready
        assign ready_o = !valid_o || ready_i;
    end

    assign accept = valid_i && ready_o;
    assign drain  = valid_o && ready_i;

    always_comb begin
        state_d      = state_q;
        main_wb_d    = main_wb_q;
        main_rdata_d = main_rdata_q;
        main_alu_d   = main_alu_q;
        main_rd_d    = main_rd_q;
        skid_wb_d    = skid_wb_q;
        skid_rdata_d = skid_rdata_q;
        skid_alu_d   = skid_alu_q;
        skid_rd_d    = skid_rd_q;
        stall_d      = stall_q;

        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d      = S_ONE;
                    main_wb_d    = WB_i;
                    main_rdata_d = read_data_i;
                    main_alu_d   = ALU_o_i;
                    main_rd_d    = Rd_i;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    main_wb_d    = WB_i;
                    main_rdata_d = read_data_i;
                    main_alu_d   = ALU_o_i;
                    main_rd_d    = Rd_i;
                end else if (accept && (SKID != 0)) begin
                    state_d      = S_TWO;
                    skid_wb_d    = WB_i;
                    skid_rdata_d = read_data_i;
                    skid_alu_d   = ALU_o_i;
                    skid_rd_d    = Rd_i;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    state_d      = S_ONE;
                    main_wb_d    = skid_wb_q;
                    main_rdata_d = skid_rdata_q;
                    main_alu_d   = skid_alu_q;
                    main_rd_d    = skid_rd_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush_i) begin
            state_d   = S_EMPTY;
            skid_wb_d = '0;
        end

        // No write-back control may be visible while the stage is empty.
        if (state_d == S_EMPTY) begin
            main_wb_d = '0;
        end

        if (valid_o && !ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_EMPTY;
            main_wb_q    <= '0;
            main_rdata_q <= '0;
            main_alu_q   <= '0;
            main_rd_q    <= '0;
            skid_wb_q    <= '0;
            skid_rdata_q <= '0;
            skid_alu_q   <= '0;
            skid_rd_q    <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_wb_q    <= main_wb_d;
            main_rdata_q <= main_rdata_d;
            main_alu_q   <= main_alu_d;
            main_rd_q    <= main_rd_d;
            skid_wb_q    <= skid_wb_d;
            skid_rdata_q <= skid_rdata_d;
            skid_alu_q   <= skid_alu_d;
            skid_rd_q    <= skid_rd_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: a skid instance (CNT_W=4) and a pass-through
// instance (SKID=0) share stimulus and are each compared to a queue model.
module tb_mem_wb_skid_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        valid_i, flush_i, ready_i;
    logic [1:0]  WB_i;
    logic [31:0] read_data_i, ALU_o_i;
    logic [4:0]  Rd_i;

    logic        s_ready, s_valid, n_ready, n_valid;
    logic [1:0]  s_wb, n_wb, s_occ, n_occ;
    logic [31:0] s_rdata, s_alu, n_rdata, n_alu;
    logic [4:0]  s_rd, n_rd;
    logic [3:0]  s_stall;
    logic [15:0] n_stall;

    int checks = 0;
    int errors = 0;

    entry_t q1[$];
    entry_t q0[$];
    int     cnt1 = 0;
    int     cnt0 = 0;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.WB_W(2), .DATA_W(32), .RD_W(5), .SKID(1), .CNT_W(4)) u_skid (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(s_ready),
        .WB_i(WB_i), .read_data_i(read_data_i), .ALU_o_i(ALU_o_i), .Rd_i(Rd_i),
        .flush_i(flush_i), .valid_o(s_valid), .ready_i(ready_i), .WB_o(s_wb),
        .read_data_o(s_rdata), .ALU_o_o(s_alu), .Rd_o(s_rd), .occ_o(s_occ),
        .stall_cnt_o(s_stall)
    );

    mem_wb_skid_stage #(.WB_W(2), .DATA_W(32), .RD_W(5), .SKID(0), .CNT_W(16)) u_noskid (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(n_ready),
        .WB_i(WB_i), .read_data_i(read_data_i), .ALU_o_i(ALU_o_i), .Rd_i(Rd_i),
        .flush_i(flush_i), .valid_o(n_valid), .ready_i(ready_i), .WB_o(n_wb),
        .read_data_o(n_rdata), .ALU_o_o(n_alu), .Rd_o(n_rd), .occ_o(n_occ),
        .stall_cnt_o(n_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_s_occ",   64'(s_occ),   64'd0);
        chk("rst_s_wb",    64'(s_wb),    64'd0);
        chk("rst_s_rdata", 64'(s_rdata), 64'd0);
        chk("rst_s_alu",   64'(s_alu),   64'd0);
        chk("rst_s_rd",    64'(s_rd),    64'd0);
        chk("rst_s_stall", 64'(s_stall), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_n_valid", 64'(n_valid), 64'd0);
        chk("rst_n_wb",    64'(n_wb),    64'd0);
        chk("rst_n_stall", 64'(n_stall), 64'd0);
        chk("rst_n_ready", 64'(n_ready), 64'd1);
    endtask

    task automatic chk_outputs();
        entry_t h1, h0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        chk("s_valid", 64'(s_valid), 64'(q1.size() > 0));
        chk("s_occ",   64'(s_occ),   64'(q1.size()));
        chk("s_wb",    64'(s_wb),    64'(h1.wb));
        chk("s_stall", 64'(s_stall), 64'(cnt1));
        if (q1.size() > 0) begin
            chk("s_rdata", 64'(s_rdata), 64'(h1.rdata));
            chk("s_alu",   64'(s_alu),   64'(h1.alu));
            chk("s_rd",    64'(s_rd),    64'(h1.rd));
        end
        chk("n_valid", 64'(n_valid), 64'(q0.size() > 0));
        chk("n_occ",   64'(n_occ),   64'(q0.size()));
        chk("n_wb",    64'(n_wb),    64'(h0.wb));
        chk("n_stall", 64'(n_stall), 64'(cnt0));
        if (q0.size() > 0) begin
            chk("n_rdata", 64'(n_rdata), 64'(h0.rdata));
            chk("n_alu",   64'(n_alu),   64'(h0.alu));
            chk("n_rd",    64'(n_rd),    64'(h0.rd));
        end
    endtask

    // One clock cycle: drive, check ready before the edge, advance model, check after.
    task automatic cycle(input bit v, input logic [1:0] wb, input logic [4:0] rd,
                         input logic [31:0] alu, input bit fl, input bit rdy);
        entry_t in;
        bit     r1, r0, v1, v0;
        valid_i     = v;
        WB_i        = wb;
        Rd_i        = rd;
        ALU_o_i     = alu;
        read_data_i = $urandom;
        flush_i     = fl;
        ready_i     = rdy;
        in          = '{wb: wb, rdata: read_data_i, alu: alu, rd: rd};
        #2;
        r1 = (q1.size() < 2);
        r0 = (q0.size() == 0) || rdy;
        chk("s_ready", 64'(s_ready), 64'(r1));
        chk("n_ready", 64'(n_ready), 64'(r0));
        v1 = (q1.size() > 0);
        v0 = (q0.size() > 0);
        @(posedge clk);
        if (v1 && !rdy && cnt1 < 15) cnt1++;
        if (v0 && !rdy && cnt0 < 65535) cnt0++;
        if (v1 && rdy) void'(q1.pop_front());
        if (v0 && rdy) void'(q0.pop_front());
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (v && r1) q1.push_back(in);
            if (v && r0) q0.push_back(in);
        end
        #1;
        chk_outputs();
    endtask

    initial begin
        rst_n_i = 1'b0;
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        WB_i = '0; read_data_i = '0; ALU_o_i = '0; Rd_i = '0;
        #12;
        chk_reset();
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 5'(i), 32'(i * 16), 1'b0, 1'b1);
            chk("stream_rd", 64'(s_rd), 64'(i));
        end
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);

        // Skid fill and drain
        cycle(1'b1, 2'b11, 5'd5, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 5'd6, 32'h66, 1'b0, 1'b0);
        chk("skid_occ2", 64'(s_occ), 64'd2);
        chk("skid_rd5",  64'(s_rd),  64'd5);
        cycle(1'b1, 2'b01, 5'd9, 32'h99, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("skid_rd6",  64'(s_rd),  64'd6);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);

        // Flush with a concurrent input
        cycle(1'b1, 2'b01, 5'd11, 32'hB0, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 5'd12, 32'hC0, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 5'd7,  32'h70, 1'b1, 1'b0);
        chk("flush_valid", 64'(s_valid), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);

        // Counter saturation, then flush leaves it saturated
        cycle(1'b1, 2'b10, 5'd3, 32'h33, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("sat_15", 64'(s_stall), 64'd15);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("sat_flush", 64'(s_stall), 64'd15);

        // Pass-through mode: combinational ready and bubble-free reload
        cycle(1'b1, 2'b01, 5'd20, 32'h200, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 5'd0,  32'd0,   1'b0, 1'b0);
        cycle(1'b1, 2'b11, 5'd21, 32'h210, 1'b0, 1'b1);
        chk("noskid_reload", 64'(n_rd), 64'd21);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges with two entries held
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 2'b01, 5'd5, 32'h5, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 5'd6, 32'h6, 1'b0, 1'b0);
        chk("pre_rst_occ", 64'(s_occ), 64'd2);
        valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset();
        q1.delete();
        q0.delete();
        cnt1 = 0;
        cnt0 = 0;
        @(negedge clk);
        rst_n_i = 1'b1;
        cycle(1'b1, 2'b11, 5'd17, 32'h1717, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_stage.md
# mem_wb_skid_stage

Parametrised MEM/WB pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, a synchronous flush, and a saturating back-pressure counter. It sits between the MEM stage and the register-file write-back in the pipelined CPU. It carries the WB control field, the memory read data, the ALU result and the destination register. Unlike a plain per-cycle register, it can hold data under WB stall, kill in-flight instructions on flush, and guarantee that no write-back control escapes while invalid.

## Interface
- WB_W, 2, width of WB control field (bit 0 = RegWrite, bit 1 = MemtoReg)
- DATA_W, 32, width of read_data and ALU result
- RD_W, 5, width of destination register index
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o
- CNT_W, 16, width of stall counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  upstream (MEM) payload valid
- ready_o  out  1  stage can accept this cycle
- WB_i  in  WB_W  WB control
- read_data_i  in  DATA_W  data-memory read data
- ALU_o_i  in  DATA_W  ALU result
- Rd_i  in  RD_W  destination register
- flush_i  in  1  synchronous kill of all held entries and the current input
- valid_o  out  1  output payload valid
- ready_i  in  1  downstream (WB) can consume
- WB_o  out  WB_W  WB control; forced 0 whenever valid_o = 0
- read_data_o  out  DATA_W  held read data
- ALU_o_o  out  DATA_W  held ALU result
- Rd_o  out  RD_W  held destination register
- occ_o  out  2  entries held (0..2; max 1 when SKID = 0)
- stall_cnt_o  out  CNT_W  cycles with valid_o & !ready_i, saturating

## Operation
- accept = valid_i & ready_o; drain = valid_o & ready_i.
- Payload = {WB, read_data, ALU_o, Rd}. A main register drives the outputs. A skid register exists only when SKID = 1.
- State machine (SKID = 1), states EMPTY / ONE / TWO; occ_o = 0/1/2:
  - EMPTY: accept -> ONE, main <= in.
  - ONE: accept & drain -> ONE, main <= in. accept & !drain -> TWO, skid <= in. !accept & drain -> EMPTY. Otherwise hold.
  - TWO: drain -> ONE, main <= skid. Otherwise hold. accept is impossible in TWO.
  - ready_o = (state != TWO), decoded from state only; no combinational path from ready_i.
- SKID = 0: states EMPTY / ONE only. ready_o = !valid_o | ready_i (combinational). accept & drain reloads main.
- valid_o = (state != EMPTY).
- Whenever the next state is EMPTY, the main WB field is written 0, so WB_o = 0 while valid_o = 0. The data fields hold their last values.
- flush_i has the highest priority:
  - next state = EMPTY and WB fields are cleared.
  - An input accepted in the same cycle is dropped.
  - A drain in the same cycle still counts as consumed downstream; the flush does not retract it.
- stall_cnt_o increments by 1 on each cycle with valid_o & !ready_i and holds at 2^CNT_W−1. Only reset clears it; flush does not.
- Order of entries is strictly FIFO. An entry is never duplicated or lost except through flush.

## Timing
- Reset (rst_n_i low, asynchronous): state EMPTY, valid_o 0, occ_o 0, WB_o 0, read_data_o 0, ALU_o_o 0, Rd_o 0, stall_cnt_o 0, ready_o 1.
- Release of reset is synchronous to clk_i. The first accept can occur on the first rising edge with rst_n_i high.
- Latency: accept at edge N -> valid_o and payload visible after edge N, consumable at edge N+1.
- Throughput: 1 entry/cycle sustained while ready_i = 1.
- SKID = 1: after ready_i falls, one further entry is absorbed (into skid). ready_o drops the cycle after TWO is entered. ready_o rises the cycle after the drain from TWO.
- Reset asserted mid-operation discards all entries immediately, without waiting for an edge.

## Test plan
- Streaming: ready_i = 1; inputs Rd = 1,2,3,4 with ALU = 0x10,0x20,0x30,0x40 on consecutive cycles -> outputs appear one cycle later in order; occ_o stays 1; stall_cnt_o stays 0.
- Skid fill: SKID = 1; hold ready_i = 0 while sending Rd = 5 then Rd = 6 -> occ_o = 2, ready_o = 0 and Rd_o = 5. After raising ready_i -> Rd_o = 5 then 6; ready_o returns to 1 one cycle after the first drain.
- Flush: occ_o = 2 with WB = 2'b01 entries; pulse flush_i with valid_i = 1 and Rd = 7 -> next cycle valid_o = 0, WB_o = 0, occ_o = 0; Rd = 7 never appears.
- Saturation: CNT_W = 4; valid_o = 1 with ready_i = 0 for 20 cycles -> stall_cnt_o = 15 and holds; flush leaves it at 15; reset gives 0.
- SKID = 0 mode: ready_i = 0 with one entry held -> ready_o = 0 in the same cycle. Raising ready_i with valid_i = 1 -> ready_o = 1 in the same cycle and main reloads with no bubble.
- Async reset: assert rst_n_i between edges while occ_o = 2 -> all outputs reach their reset values before the next edge.
